// File: rtl/morse_pkg.sv
// morse_pkg: Morse timing constants and keyer state encodings
package morse_pkg;
  localparam int DOT_UNITS = 1;
  localparam int DASH_UNITS = 3;
  localparam int SYM_GAP_UNITS = 1;
  localparam int LETTER_GAP_UNITS = 3;
  localparam int DEF_MAX_SYMS = 5;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MARK  = 3'd1,
    S_SPACE = 3'd2,
    S_LGAP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/mod_unit_timer.sv
// mod_unit_timer: one-cycle tick every UNIT cycles while clear is low
module mod_unit_timer #(
  parameter int UNIT = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int W = (UNIT > 2) ? $clog2(UNIT) : 1;
  logic [W-1:0] cnt;
  assign tick = !clear && (cnt == W'(UNIT - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/mod_morse_keyer.sv
// mod_morse_keyer: plays one Morse character on key_out, then pulses done
module mod_morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT = 50,
  parameter int MAX_SYMS = DEF_MAX_SYMS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [MAX_SYMS-1:0] sym_bits,
  input  logic [2:0]          sym_len,
  output logic                key_out,
  output logic                busy,
  output logic                done
);
  state_t state;
  logic [MAX_SYMS-1:0] sr;
  logic [2:0] rem, len_sat;
  logic [1:0] units, need;
  logic armed, tick, clear, expire;
  assign len_sat = (sym_len > 3'(MAX_SYMS)) ? 3'(MAX_SYMS) : sym_len;
  // timer idles in IDLE/DONE; every other transition lands on a tick, so the count is already 0 on entry
  assign clear = (state == S_IDLE) || (state == S_DONE);
  always_comb
    need = (state == S_MARK) ? (sr[0] ? 2'(DASH_UNITS) : 2'(DOT_UNITS)) :
           (state == S_SPACE) ? 2'(SYM_GAP_UNITS) : 2'(LETTER_GAP_UNITS);
  assign expire = tick && (units == need - 2'd1);
  mod_unit_timer #(.UNIT(UNIT)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .tick (tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= S_IDLE;
      sr      <= '0;
      rem     <= '0;
      units   <= '0;
      armed   <= 1'b1;
      key_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (tick) units <= expire ? 2'd0 : units + 2'd1;
      case (state)
        S_IDLE:
          if (!start) armed <= 1'b1;
          else if (armed) begin
            armed <= 1'b0;
            sr    <= sym_bits;
            rem   <= len_sat;
            if (len_sat == 3'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state   <= S_MARK;
              key_out <= 1'b1;
              busy    <= 1'b1;
            end
          end
        S_MARK:
          if (expire) begin
            sr      <= sr >> 1;
            rem     <= rem - 3'd1;
            key_out <= 1'b0;
            state   <= (rem == 3'd1) ? S_LGAP : S_SPACE;
          end
        S_SPACE:
          if (expire) begin
            state   <= S_MARK;
            key_out <= 1'b1;
          end
        S_LGAP:
          if (expire) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule
